// File: rtl/rlc_filter.sv
// rlc_filter: series RLC low-pass emulation (v_out = capacitor voltage), one symplectic Euler step per emu_clk.
// Define RLC_STATE_SAT_EN to clamp state and output on overflow instead of wrapping.
module rlc_filter #(
  parameter int IN_WIDTH    = 16,
  parameter int IN_EXP      = -14,
  parameter int OUT_WIDTH   = 18,
  parameter int OUT_EXP     = -10,
  parameter int STATE_WIDTH = 32,
  parameter int STATE_EXP   = -24,
  parameter int COEF_FRAC   = 20,
  parameter int K_L         = 10486,
  parameter int K_R         = 5243,
  parameter int K_C         = 10486
) (
  input  logic                        emu_clk,
  input  logic                        emu_rst,
  input  logic signed [IN_WIDTH-1:0]  v_in,
  output logic signed [OUT_WIDTH-1:0] v_out
);
  localparam int P   = STATE_WIDTH + COEF_FRAC + 2;
  localparam int SH  = IN_EXP - STATE_EXP;
  localparam int OSH = OUT_EXP - STATE_EXP;
  localparam logic signed [P-1:0] KL = P'(K_L);
  localparam logic signed [P-1:0] KR = P'(K_R);
  localparam logic signed [P-1:0] KC = P'(K_C);
`ifdef RLC_STATE_SAT_EN
  localparam logic signed [P-1:0] S_MAX = P'({1'b0, {(STATE_WIDTH-1){1'b1}}});
  localparam logic signed [P-1:0] S_MIN = ~S_MAX;
  localparam logic signed [P-1:0] O_MAX = P'({1'b0, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [P-1:0] O_MIN = ~O_MAX;
  function automatic logic signed [STATE_WIDTH-1:0] fit_s(input logic signed [P-1:0] x);
    return STATE_WIDTH'(x > S_MAX ? S_MAX : x < S_MIN ? S_MIN : x);
  endfunction
  function automatic logic signed [OUT_WIDTH-1:0] fit_o(input logic signed [P-1:0] x);
    return OUT_WIDTH'(x > O_MAX ? O_MAX : x < O_MIN ? O_MIN : x);
  endfunction
`else
  function automatic logic signed [STATE_WIDTH-1:0] fit_s(input logic signed [P-1:0] x);
    return STATE_WIDTH'(x);
  endfunction
  function automatic logic signed [OUT_WIDTH-1:0] fit_o(input logic signed [P-1:0] x);
    return OUT_WIDTH'(x);
  endfunction
`endif
  logic signed [STATE_WIDTH-1:0] i_l_q, i_l_d, v_c_q, v_c_d;
  logic signed [OUT_WIDTH-1:0]   v_out_q, v_out_d;
  logic signed [P-1:0]           u, i_sum, v_c_sum;
  // capacitor update uses the freshly computed current (semi-implicit step)
  always_comb begin
    u = P'(v_in) <<< SH;
    i_sum = P'(i_l_q) + ((KL * (u - P'(v_c_q)) - KR * P'(i_l_q)) >>> COEF_FRAC);
    i_l_d = fit_s(i_sum);
    v_c_sum = P'(v_c_q) + ((KC * P'(i_l_d)) >>> COEF_FRAC);
    v_c_d = fit_s(v_c_sum);
    v_out_d = fit_o(P'(v_c_d) >>> OSH);
  end
  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      i_l_q <= '0;
      v_c_q <= '0;
      v_out_q <= '0;
    end else begin
      i_l_q <= i_l_d;
      v_c_q <= v_c_d;
      v_out_q <= v_out_d;
    end
  end
  assign v_out = v_out_q;
endmodule

// File: tb/tb_rlc_filter.sv
// tb_rlc_filter: scoreboard bench for rlc_filter against a 64-bit reference of the RLC step equations.
module tb_rlc_filter;
  logic               emu_clk = 1'b0;
  logic               emu_rst, rst_s;
  logic signed [15:0] v_in, v_in_s;
  logic signed [17:0] v_out, v_out_s;
  int     n_cmp = 0, n_err = 0;
  int     exp_q[$];
  int     trace[600];
  longint m_i = 0, m_vc = 0;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  rlc_filter dut (.emu_clk(emu_clk), .emu_rst(emu_rst), .v_in(v_in), .v_out(v_out));
  rlc_filter #(.K_L(1 << 20), .K_R(0), .K_C(0)) dut_s (.emu_clk(emu_clk), .emu_rst(rst_s), .v_in(v_in_s), .v_out(v_out_s));

  always #5 emu_clk = ~emu_clk;

  function automatic longint fit32(input longint x);
`ifdef RLC_STATE_SAT_EN
    return x > SMAX ? SMAX : x < SMIN ? SMIN : x;
`else
    return longint'(int'(x));
`endif
  endfunction

  task automatic model_step(input int v, input bit r, output int e);
    longint u;
    if (r) begin
      m_i = 0;
      m_vc = 0;
    end else begin
      u = longint'(v) * 1024;
      m_i = fit32(m_i + ((10486 * (u - m_vc) - 5243 * m_i) >>> 20));
      m_vc = fit32(m_vc + ((10486 * m_i) >>> 20));
    end
    e = int'(m_vc >>> 14);
  endtask

  task automatic step(input int v, input bit r);
    int e;
    v_in = 16'(v);
    emu_rst = r;
    model_step(v, r, e);
    exp_q.push_back(e);
    @(posedge emu_clk);
    #1;
  endtask

  task automatic test_reset;
    int e;
    for (int k = 0; k < 5; k++) begin
      step(16384, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if (v_out !== e) begin n_err++; $display("FAIL reset_vout k=%0d got=%0d exp=%0d", k, v_out, e); end
      n_cmp++;
      if (dut.i_l_q !== 0) begin n_err++; $display("FAIL reset_il k=%0d got=%0d exp=0", k, dut.i_l_q); end
    end
  endtask

  task automatic test_first_step;
    int e;
    step(16384, 1'b0);
    e = exp_q.pop_front();
    trace[0] = e;
    n_cmp++;
    if (v_out !== e) begin n_err++; $display("FAIL first_vout got=%0d exp=%0d", v_out, e); end
    n_cmp++;
    if (dut.i_l_q !== 167776) begin n_err++; $display("FAIL first_il got=%0d exp=167776", dut.i_l_q); end
    n_cmp++;
    if (dut.v_c_q !== 1677) begin n_err++; $display("FAIL first_vc got=%0d exp=1677", dut.v_c_q); end
    n_cmp++;
    if (v_out !== 0) begin n_err++; $display("FAIL first_vout_zero got=%0d exp=0", v_out); end
  endtask

  task automatic test_step_response;
    int e, pk, pk_k, bad;
    pk = -1000000; pk_k = 0; bad = 0;
    for (int k = 2; k <= 2000; k++) begin
      step(16384, 1'b0);
      e = exp_q.pop_front();
      if (k <= 600) trace[k-1] = e;
      n_cmp++;
      if (v_out !== e) begin n_err++; $display("FAIL step_vout k=%0d got=%0d exp=%0d", k, v_out, e); end
      if (v_out > pk) begin pk = v_out; pk_k = k; end
      if (k >= 1700 && (v_out < 1004 || v_out > 1044)) bad++;
    end
    n_cmp++;
    if (pk < 1465 || pk > 1485) begin n_err++; $display("FAIL step_peak got=%0d exp=1465..1485", pk); end
    n_cmp++;
    if (pk_k < 314 || pk_k > 334) begin n_err++; $display("FAIL step_peak_cycle got=%0d exp=314..334", pk_k); end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL step_settle out_of_band=%0d exp=0", bad); end
    n_cmp++;
    if (dut.i_l_q > 335544 || dut.i_l_q < -335544) begin n_err++; $display("FAIL step_il_decay got=%0d exp=|i|<335544", dut.i_l_q); end
  endtask

  task automatic test_square;
    int e, mx, mn;
    longint sum;
    mx = -1000000; mn = 1000000; sum = 0;
    step(0, 1'b1);
    e = exp_q.pop_front();
    n_cmp++;
    if (v_out !== e) begin n_err++; $display("FAIL square_reset got=%0d exp=%0d", v_out, e); end
    for (int k = 0; k < 4000; k++) begin
      step(((k / 50) % 2 == 0) ? 16384 : -16384, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if (v_out !== e) begin n_err++; $display("FAIL square_vout k=%0d got=%0d exp=%0d", k, v_out, e); end
      if (v_out > mx) mx = v_out;
      if (v_out < mn) mn = v_out;
      if (k >= 3000) sum += v_out;
    end
    n_cmp++;
    if (mx > 1536 || mn < -1536) begin n_err++; $display("FAIL square_bound max=%0d min=%0d exp=within +-1536", mx, mn); end
    n_cmp++;
    if (sum > 51000 || sum < -51000) begin n_err++; $display("FAIL square_mean sum1000=%0d exp=|sum|<=51000", sum); end
  endtask

  task automatic test_midrun_reset;
    int e;
    step(16384, 1'b1);
    void'(exp_q.pop_front());
    for (int k = 1; k <= 200; k++) begin
      step(16384, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if (v_out !== e) begin n_err++; $display("FAIL midrun_pre k=%0d got=%0d exp=%0d", k, v_out, e); end
    end
    step(16384, 1'b1);
    e = exp_q.pop_front();
    n_cmp++;
    if (v_out !== 0 || e != 0) begin n_err++; $display("FAIL midrun_reset got=%0d exp=0", v_out); end
    for (int j = 0; j < 600; j++) begin
      step(16384, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if (v_out !== e) begin n_err++; $display("FAIL midrun_post j=%0d got=%0d exp=%0d", j, v_out, e); end
      n_cmp++;
      if (v_out !== trace[j]) begin n_err++; $display("FAIL midrun_replay j=%0d got=%0d exp=%0d", j, v_out, trace[j]); end
    end
  endtask

  task automatic test_saturation;
    int exp65, exp66;
`ifdef RLC_STATE_SAT_EN
    exp65 = 2147483647; exp66 = 2147483647;
`else
    exp65 = -2124845056; exp66 = -2091458560;
`endif
    emu_rst = 1'b1;
    rst_s = 1'b1;
    @(posedge emu_clk); #1;
    rst_s = 1'b0;
    v_in_s = 16'sd32604;
    repeat (64) begin @(posedge emu_clk); #1; end
    n_cmp++;
    if (dut_s.i_l_q !== 2136735744) begin n_err++; $display("FAIL sat_ramp got=%0d exp=2136735744", dut_s.i_l_q); end
    @(posedge emu_clk); #1;
    n_cmp++;
    if (dut_s.i_l_q !== exp65) begin n_err++; $display("FAIL sat_edge65 got=%0d exp=%0d", dut_s.i_l_q, exp65); end
    @(posedge emu_clk); #1;
    n_cmp++;
    if (dut_s.i_l_q !== exp66) begin n_err++; $display("FAIL sat_edge66 got=%0d exp=%0d", dut_s.i_l_q, exp66); end
    n_cmp++;
    if (v_out_s !== 0) begin n_err++; $display("FAIL sat_vout got=%0d exp=0", v_out_s); end
  endtask

  initial begin
    v_in = '0;
    emu_rst = 1'b1;
    v_in_s = '0;
    rst_s = 1'b1;
    test_reset;
    test_first_step;
    test_step_response;
    test_square;
    test_midrun_reset;
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
